// File: rtl/sdram_port_arbiter.sv
// Arbitrates the SDRAM controller between LCD refill burst reads (priority) and renderer writes.
// Define ARB_WRITE_PREEMPT_EN to let a rising display read need cut a write run short.
module sdram_port_arbiter #(
    parameter int ADDR_WIDTH        = 22,
    parameter int DATA_WIDTH        = 32,
    parameter int FRAME_PIXELS      = 384000,
    parameter int READ_BURST_LENGTH = 8,
    parameter int FIFO_PTR_WIDTH    = 10,
    parameter int RD_LOW_WATER      = 496,
    parameter int WRITE_MAX_RUN     = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [FIFO_PTR_WIDTH-1:0] rd_fifo_used,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_data_valid,
    output logic                      rd_first_ready,
    input  logic                      wr_valid,
    input  logic [ADDR_WIDTH-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    output logic                      wr_ready,
    output logic [1:0]                mem_command,
    output logic [ADDR_WIDTH-1:0]     mem_address,
    output logic [DATA_WIDTH-1:0]     mem_write_data,
    input  logic [DATA_WIDTH-1:0]     mem_read_data,
    input  logic                      mem_read_valid,
    input  logic                      mem_write_done
);

    localparam int BEAT_W = (READ_BURST_LENGTH > 1) ? $clog2(READ_BURST_LENGTH) : 1;
    localparam int RUN_W  = (WRITE_MAX_RUN > 1) ? $clog2(WRITE_MAX_RUN) : 1;
    localparam logic [BEAT_W-1:0]         BEAT_LAST  = BEAT_W'(READ_BURST_LENGTH - 1);
    localparam logic [RUN_W-1:0]          RUN_LAST   = RUN_W'(WRITE_MAX_RUN - 1);
    localparam logic [ADDR_WIDTH-1:0]     FRAME_LAST = ADDR_WIDTH'(FRAME_PIXELS - 1);
    localparam logic [FIFO_PTR_WIDTH-1:0] LOW_WATER  = FIFO_PTR_WIDTH'(RD_LOW_WATER);

    // State encoding doubles as the controller command.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t              state;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [BEAT_W-1:0]     beat_cnt;
    logic [RUN_W-1:0]      run_cnt;

    logic rd_need;
    logic wr_addr_ok;
    logic run_may_continue;
    logic read_beat;
    logic write_done;
    logic drop_word;

    assign rd_need    = enable && (rd_fifo_used <= LOW_WATER);
    assign wr_addr_ok = (wr_addr <= FRAME_LAST);
    assign read_beat  = (state == ST_READ) && mem_read_valid;
    assign write_done = (state == ST_WRITE) && mem_write_done;
    // Out-of-frame words are consumed and discarded so the renderer never stalls on them.
    assign drop_word  = rst_n && (state == ST_IDLE) && !rd_need && wr_valid && !wr_addr_ok;

`ifdef ARB_WRITE_PREEMPT_EN
    assign run_may_continue = !rd_need;
`else
    assign run_may_continue = 1'b1;
`endif

    always_comb begin
        mem_command    = state;
        mem_address    = '0;
        mem_write_data = '0;
        rd_data        = '0;
        rd_data_valid  = read_beat;
        wr_ready       = write_done || drop_word;
        if (state == ST_READ) begin
            mem_address = rd_ptr;
        end else if (state == ST_WRITE) begin
            mem_address    = wr_addr;
            mem_write_data = wr_data;
        end
        if (read_beat) begin
            rd_data = mem_read_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            rd_ptr         <= '0;
            beat_cnt       <= '0;
            run_cnt        <= '0;
            rd_first_ready <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rd_need) begin
                        state    <= ST_READ;
                        beat_cnt <= '0;
                    end else if (wr_valid && wr_addr_ok) begin
                        state   <= ST_WRITE;
                        run_cnt <= '0;
                    end
                end
                ST_READ: begin
                    if (mem_read_valid) begin
                        rd_ptr   <= (rd_ptr == FRAME_LAST) ? '0 : rd_ptr + 1'b1;
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == BEAT_LAST) begin
                            state          <= ST_IDLE;
                            rd_first_ready <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (mem_write_done) begin
                        run_cnt <= run_cnt + 1'b1;
                        if (!(run_may_continue && (run_cnt < RUN_LAST))) begin
                            state <= ST_IDLE;
                        end
                    end else if (!wr_valid || !wr_addr_ok) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized bench for sdram_port_arbiter against a rule-level reference model (small frame).
module tb_sdram_port_arbiter;

    localparam int AW  = 22;
    localparam int DW  = 32;
    localparam int FP  = 64;
    localparam int RBL = 8;
    localparam int FPW = 10;
    localparam int LW  = 496;
    localparam int WMR = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic [FPW-1:0] rd_fifo_used = '0;
    logic [DW-1:0]  rd_data;
    logic           rd_data_valid;
    logic           rd_first_ready;
    logic           wr_valid = 1'b0;
    logic [AW-1:0]  wr_addr = '0;
    logic [DW-1:0]  wr_data = '0;
    logic           wr_ready;
    logic [1:0]     mem_command;
    logic [AW-1:0]  mem_address;
    logic [DW-1:0]  mem_write_data;
    logic [DW-1:0]  mem_read_data = '0;
    logic           mem_read_valid = 1'b0;
    logic           mem_write_done = 1'b0;

    sdram_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FRAME_PIXELS(FP), .READ_BURST_LENGTH(RBL),
        .FIFO_PTR_WIDTH(FPW), .RD_LOW_WATER(LW), .WRITE_MAX_RUN(WMR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .rd_fifo_used(rd_fifo_used),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_first_ready(rd_first_ready),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .mem_command(mem_command), .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .mem_read_valid(mem_read_valid),
        .mem_write_done(mem_write_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 write, 2 read
    int m_mode, m_ptr, m_beats, m_run;
    bit m_first;

    // Stimulus knobs
    int pct_rv, pct_wd, pct_wnew, pct_bad, words_left, next_addr;
    bit seq_mode, force_bad;

    // Observed statistics
    int n_acc, n_rdv, n_wrdy, n_cmd_nz, cur_run, prev_cmd, last_rd;
    int runs[$];

    task automatic model_reset();
        m_mode = 0; m_ptr = 0; m_beats = 0; m_run = 0; m_first = 0;
        last_rd = -1; prev_cmd = 0; cur_run = 0;
    endtask

    task automatic clear_stats();
        n_acc = 0; n_rdv = 0; n_wrdy = 0; n_cmd_nz = 0; cur_run = 0;
        runs.delete();
    endtask

    task automatic cycle();
        bit need, good, e_rv, e_wr, cont, accepted;
        int e_addr;
        logic [DW-1:0] e_wdata, e_rdata;
        @(negedge clk);
        need = enable && (rd_fifo_used <= LW);
        good = (wr_addr < FP);
        e_rv = (m_mode == 2) && mem_read_valid;
        e_wr = (m_mode == 1 && mem_write_done) || (m_mode == 0 && !need && wr_valid && !good);
        e_addr  = (m_mode == 2) ? m_ptr : (m_mode == 1) ? int'(wr_addr) : 0;
        e_wdata = (m_mode == 1) ? wr_data : '0;
        e_rdata = e_rv ? mem_read_data : '0;
        check("mem_command", mem_command, m_mode);
        check("mem_address", mem_address, e_addr);
        check("mem_write_data", mem_write_data, e_wdata);
        check("rd_data_valid", rd_data_valid, e_rv);
        check("rd_data", rd_data, e_rdata);
        check("wr_ready", wr_ready, e_wr);
        check("rd_first_ready", rd_first_ready, m_first);

        if (rd_data_valid && mem_command == 2) begin
            if (last_rd == FP - 1) check("rd_wrap", mem_address, 0);
            last_rd = int'(mem_address);
            n_rdv++;
        end
        if (wr_ready) n_wrdy++;
        if (mem_command != 0) n_cmd_nz++;
        if (mem_command == 1 && wr_ready && wr_valid) begin
            cur_run++;
            n_acc++;
        end
        if (prev_cmd == 1 && mem_command != 1 && cur_run > 0) begin
            runs.push_back(cur_run);
            cur_run = 0;
        end
        prev_cmd = int'(mem_command);

`ifdef ARB_WRITE_PREEMPT_EN
        cont = !need;
`else
        cont = 1'b1;
`endif
        case (m_mode)
            0: begin
                if (need) begin m_mode = 2; m_beats = 0; end
                else if (wr_valid && good) begin m_mode = 1; m_run = 0; end
            end
            2: if (mem_read_valid) begin
                m_ptr = (m_ptr + 1) % FP;
                m_beats++;
                if (m_beats == RBL) begin m_mode = 0; m_first = 1; end
            end
            default: begin
                if (mem_write_done) begin
                    m_run++;
                    if (!cont || m_run >= WMR) m_mode = 0;
                end else if (!wr_valid || !good) m_mode = 0;
            end
        endcase
        accepted = e_wr && wr_valid;

        @(posedge clk);
        #1;
        mem_read_valid = ($urandom_range(99) < pct_rv);
        mem_read_data  = $urandom;
        mem_write_done = ($urandom_range(99) < pct_wd);
        if (accepted || !wr_valid) begin
            if (words_left > 0 && $urandom_range(99) < pct_wnew) begin
                words_left--;
                wr_valid = 1'b1;
                wr_data  = $urandom;
                if (force_bad) wr_addr = AW'(FP + $urandom_range(0, 50));
                else if (seq_mode) begin
                    wr_addr   = AW'(next_addr);
                    next_addr = (next_addr + 1) % FP;
                end else if ($urandom_range(99) < pct_bad) wr_addr = AW'(FP + $urandom_range(0, 100));
                else wr_addr = AW'($urandom_range(0, FP - 1));
            end else begin
                wr_valid = 1'b0;
            end
        end
    endtask

    initial begin
        bit found;
        pct_rv = 0; pct_wd = 0; pct_wnew = 0; pct_bad = 0; words_left = 0; next_addr = 0;
        seq_mode = 0; force_bad = 0;
        model_reset();
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd", mem_command, 0);
        check("rst_first", rd_first_ready, 0);
        rst_n = 1'b1;

        // Idle -> read burst -> idle -> read, and pointer wrap over a small frame
        enable = 1'b1; rd_fifo_used = '0; pct_rv = 100;
        repeat (10) cycle();
        check("first_burst_beats", n_rdv, 8);
        check("first_ready_set", rd_first_ready, 1);
        repeat (100) cycle();

        // 40 sequential writes split into runs of 16,16,8
        rd_fifo_used = FPW'(500); pct_rv = 30; pct_wd = 100; pct_wnew = 100;
        seq_mode = 1; next_addr = 0; words_left = 40;
        clear_stats();
        repeat (120) cycle();
        check("write_accepts", n_acc, 40);
        check("write_run_count", runs.size(), 3);
        if (runs.size() == 3) begin
            check("run0", runs[0], 16);
            check("run1", runs[1], 16);
            check("run2", runs[2], 8);
        end

        // Out-of-frame word is dropped without a grant
        enable = 1'b0; force_bad = 1; words_left = 1;
        clear_stats();
        repeat (10) cycle();
        check("drop_wr_ready", n_wrdy, 1);
        check("drop_no_grant", n_cmd_nz, 0);
        force_bad = 0;

        // Read need rising during a write run
        enable = 1'b1; rd_fifo_used = FPW'(500); pct_rv = 50; pct_wd = 100;
        seq_mode = 1; next_addr = 8; words_left = 40;
        clear_stats();
        for (int i = 0; i < 120; i++) begin
            cycle();
            if (n_acc >= 3) rd_fifo_used = FPW'(400);
        end
`ifdef ARB_WRITE_PREEMPT_EN
        if (runs.size() > 0) check("preempt_run", runs[0], 4);
        else check("preempt_run_seen", 0, 1);
`else
        if (runs.size() > 0) check("nopreempt_run", runs[0], 16);
        else check("nopreempt_run_seen", 0, 1);
`endif

        // Randomized mix around the low-water mark
        seq_mode = 0; pct_bad = 15; pct_wnew = 70; words_left = 1000000;
        for (int i = 0; i < 3000; i++) begin
            pct_rv = 50; pct_wd = 40;
            enable = ($urandom_range(99) < 85);
            rd_fifo_used = FPW'($urandom_range(480, 510));
            cycle();
        end

        // Asynchronous reset in the middle of a read burst
        enable = 1'b1; rd_fifo_used = '0; pct_rv = 50; found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            cycle();
            if (m_mode == 2 && m_beats >= 2) found = 1;
        end
        check("reach_mid_read", found, 1);
        mem_read_valid = 1'b1;
        wr_valid = 1'b1;
        wr_addr = AW'(FP + 3);
        enable = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_cmd", mem_command, 0);
        check("arst_rdv", rd_data_valid, 0);
        check("arst_rd_data", rd_data, 0);
        check("arst_wr_ready", wr_ready, 0);
        check("arst_first", rd_first_ready, 0);
        check("arst_addr", mem_address, 0);
        check("arst_wdata", mem_write_data, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wr_valid = 1'b0;
        enable = 1'b1; pct_wd = 50; pct_wnew = 50;
        repeat (60) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
